// File: rtl/nlc_pkg.sv
// Shared definitions for the NLC channel scheduler: default sizes, the
// operation-mode encoding and the scheduler FSM state enum.
package nlc_pkg;

    localparam int NLC_NUM_CH_DEF = 16;
    localparam int NLC_XW_DEF     = 21;
    localparam int NLC_CH_W       = 4;

    typedef enum logic [1:0] {
        MODE_EXTERNAL = 2'b00,
        MODE_UPGRADE  = 2'b01,
        MODE_ERROR    = 2'b10,
        MODE_STORED   = 2'b11
    } nlc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } nlc_state_e;

endpackage

// File: rtl/nlc_ch_scheduler_if.sv
// Issue/result link between the channel scheduler and the shared NLC core.
//
// Handshake: the issue side is strict valid/ready. A transfer happens on a
// rising edge where core_vld_o and core_rdy_i are both high; while core_vld_o
// is high and core_rdy_i is low, core_ch_o/core_x_adc_o/core_mode_o are held
// stable and core_vld_o is not withdrawn. The result side is valid-only: the
// core presents core_vld_i with core_ch_i/core_x_lin_i for one cycle and the
// scheduler always accepts it (no back-pressure towards the core).
interface nlc_ch_scheduler_if #(
    parameter int XW = nlc_pkg::NLC_XW_DEF
);
    import nlc_pkg::*;

    logic                core_vld_o;
    logic                core_rdy_i;
    logic [NLC_CH_W-1:0] core_ch_o;
    logic [XW-1:0]       core_x_adc_o;
    logic [1:0]          core_mode_o;
    logic                core_vld_i;
    logic [NLC_CH_W-1:0] core_ch_i;
    logic [XW-1:0]       core_x_lin_i;

    // Scheduler view
    modport master (
        output core_vld_o, core_ch_o, core_x_adc_o, core_mode_o,
        input  core_rdy_i, core_vld_i, core_ch_i, core_x_lin_i
    );

    // Core view
    modport slave (
        input  core_vld_o, core_ch_o, core_x_adc_o, core_mode_o,
        output core_rdy_i, core_vld_i, core_ch_i, core_x_lin_i
    );

    // Result storage view: only the returning results
    modport bank (
        input core_vld_i, core_ch_i, core_x_lin_i
    );

endinterface

// File: rtl/nlc_result_bank.sv
// Per-channel result registers, the done mask and the all-done detect.
// Results may arrive in any order; a repeated channel overwrites its data.
module nlc_result_bank
    import nlc_pkg::*;
#(
    parameter int NUM_CH = NLC_NUM_CH_DEF,
    parameter int XW     = NLC_XW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 accept_i,
    nlc_ch_scheduler_if.bank     rif,
    output logic [NUM_CH*XW-1:0] result_flat_o,
    output logic                 all_done_o
);

    logic [XW-1:0]     result_q [NUM_CH];
    logic [XW-1:0]     result_d [NUM_CH];
    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] done_d;

    // Write an accepted result into its channel slot; channel codes with no
    // slot simply match nothing and are dropped.
    always_comb begin
        result_d = result_q;
        done_d   = done_q;
        if (clear_i) begin
            done_d = '0;
        end else if (accept_i && rif.core_vld_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rif.core_ch_i == NLC_CH_W'(i)) begin
                    result_d[i] = rif.core_x_lin_i;
                    done_d[i]   = 1'b1;
                end
            end
        end
    end

    // Result and done-mask registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                result_q[i] <= '0;
            end
            done_q <= '0;
        end else begin
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Flatten results (ch0 in LSBs)
    always_comb begin
        result_flat_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            result_flat_o[i*XW +: XW] = result_q[i];
        end
    end

    // Looks at the mask including this cycle's write so the FSM can reach
    // DONE on the edge that stores the final result.
    assign all_done_o = &done_d;

endmodule

// File: rtl/nlc_ch_scheduler.sv
// Time-multiplexes NUM_CH ADC channels onto one shared NLC core: captures a
// frame, issues channels 0..NUM_CH-1 over a valid/ready link, collects
// results in any order and pulses srdyo once every channel has returned.
// Optional feature: define NLC_SCHED_OVERRUN_EN to build the sticky
// overrun flag (srdyi seen while busy); otherwise overrun_o is tied low.
module nlc_ch_scheduler
    import nlc_pkg::*;
#(
    parameter int NUM_CH = NLC_NUM_CH_DEF,
    parameter int XW     = NLC_XW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 srdyi,
    input  logic [1:0]           operation_mode_i,
    input  logic [NUM_CH*XW-1:0] x_adc_flat,
    output logic [NUM_CH*XW-1:0] x_lin_flat,
    output logic                 srdyo,
    output logic                 busy,
    output logic                 core_vld_o,
    input  logic                 core_rdy_i,
    output logic [3:0]           core_ch_o,
    output logic [XW-1:0]        core_x_adc_o,
    output logic [1:0]           core_mode_o,
    input  logic                 core_vld_i,
    input  logic [3:0]           core_ch_i,
    input  logic [XW-1:0]        core_x_lin_i,
    output logic                 overrun_o,
    output nlc_state_e           state_o
);

    localparam logic [NLC_CH_W-1:0] LAST_CH = NLC_CH_W'(NUM_CH - 1);

    nlc_ch_scheduler_if #(.XW(XW)) core_if ();

    nlc_state_e          state_q, state_d;
    logic [NLC_CH_W-1:0] cnt_q, cnt_d;
    logic [XW-1:0]       sample_q [NUM_CH];
    logic [XW-1:0]       sample_d [NUM_CH];
    nlc_mode_e           mode_q, mode_d;

    logic                issue_vld;
    logic [NLC_CH_W-1:0] issue_ch;
    logic [XW-1:0]       issue_x;
    logic [1:0]          issue_mode;
    logic                issue_hs;
    logic                srdyo_c;
    logic                busy_c;
    logic                capture;
    logic                accept;
    logic                all_done;
    logic [XW-1:0]       sel_x;

    assign core_if.core_rdy_i   = core_rdy_i;
    assign core_if.core_vld_i   = core_vld_i;
    assign core_if.core_ch_i    = core_ch_i;
    assign core_if.core_x_lin_i = core_x_lin_i;
    assign core_if.core_vld_o   = issue_vld;
    assign core_if.core_ch_o    = issue_ch;
    assign core_if.core_x_adc_o = issue_x;
    assign core_if.core_mode_o  = issue_mode;

    assign core_vld_o   = core_if.core_vld_o;
    assign core_ch_o    = core_if.core_ch_o;
    assign core_x_adc_o = core_if.core_x_adc_o;
    assign core_mode_o  = core_if.core_mode_o;

    assign issue_hs = issue_vld & core_if.core_rdy_i;
    assign capture  = (state_q == ST_IDLE) & srdyi;
    assign accept   = (state_q == ST_ISSUE) | (state_q == ST_DRAIN);
    assign srdyo    = srdyo_c;
    assign busy     = busy_c;
    assign state_o  = state_q;

    // FSM state register; reset abandons any frame in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; completion is checked in ISSUE too, since an
    // out-of-order core may finish before the last channel is issued
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (srdyi) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (all_done) begin
                    state_d = ST_DONE;
                end else if (issue_hs && cnt_q == LAST_CH) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (all_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; issue fields read zero outside ISSUE
    always_comb begin
        issue_vld  = 1'b0;
        issue_ch   = '0;
        issue_x    = '0;
        issue_mode = '0;
        srdyo_c    = 1'b0;
        busy_c     = 1'b1;
        case (state_q)
            ST_IDLE:  busy_c = 1'b0;
            ST_ISSUE: begin
                issue_vld  = 1'b1;
                issue_ch   = cnt_q;
                issue_x    = sel_x;
                issue_mode = mode_q;
            end
            ST_DONE:  srdyo_c = 1'b1;
            default:  ;
        endcase
    end

    // Captured sample for the channel being issued
    always_comb begin
        sel_x = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_q == NLC_CH_W'(i)) sel_x = sample_q[i];
        end
    end

    // Frame capture and issue counter; the counter only moves on a handshake
    // so a stalled issue keeps presenting the same channel
    always_comb begin
        cnt_d    = cnt_q;
        sample_d = sample_q;
        mode_d   = mode_q;
        if (capture) begin
            cnt_d  = '0;
            mode_d = nlc_mode_e'(operation_mode_i);
            for (int i = 0; i < NUM_CH; i++) begin
                sample_d[i] = x_adc_flat[i*XW +: XW];
            end
        end else if (issue_hs) begin
            cnt_d = cnt_q + NLC_CH_W'(1);
        end
    end

    // Counter, captured samples and captured mode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            mode_q <= MODE_EXTERNAL;
            for (int i = 0; i < NUM_CH; i++) begin
                sample_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            sample_q <= sample_d;
        end
    end

    nlc_result_bank #(
        .NUM_CH (NUM_CH),
        .XW     (XW)
    ) u_result_bank (
        .clk           (clk),
        .rst_n         (reset),
        .clear_i       (capture),
        .accept_i      (accept),
        .rif           (core_if.bank),
        .result_flat_o (x_lin_flat),
        .all_done_o    (all_done)
    );

`ifdef NLC_SCHED_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky: a new frame request while a frame is in flight
    always_comb begin
        overrun_d = overrun_q | (srdyi & busy_c);
    end

    // Overrun flag register, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_o = overrun_q;
`else
    assign overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_nlc_ch_scheduler.sv
// Directed bench for nlc_ch_scheduler: a loopback core model (latency 3,
// returns x+1, optionally in reverse order), a frame scoreboard checked on
// every srdyo, and direct checks of reset, back-pressure, overrun and abort.
`timescale 1ns/1ps
module tb_nlc_ch_scheduler;
    import nlc_pkg::*;

    localparam int NUM_CH = 16;
    localparam int XW     = 21;
    localparam int LAT    = 3;
`ifdef NLC_SCHED_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 srdyi;
    logic [1:0]           op_mode;
    logic [NUM_CH*XW-1:0] x_adc_flat;
    logic [NUM_CH*XW-1:0] x_lin_flat;
    logic                 srdyo;
    logic                 busy;
    logic                 overrun;
    nlc_state_e           state_dbg;

    nlc_ch_scheduler_if #(.XW(XW)) cif ();

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [NUM_CH*XW-1:0] exp_q[$];
    int                   exp_cyc_q[$];

    logic [3:0]    pend_ch[$];
    logic [XW-1:0] pend_x[$];
    int            pend_due[$];
    bit            rev_mode = 1'b0;
    bit            rev_go   = 1'b0;
    bit            inj_pend = 1'b0;
    logic [3:0]    inj_ch;
    logic [XW-1:0] inj_x;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nlc_ch_scheduler #(.NUM_CH(NUM_CH), .XW(XW)) dut (
        .clk              (clk),
        .reset            (rst_n),
        .srdyi            (srdyi),
        .operation_mode_i (op_mode),
        .x_adc_flat       (x_adc_flat),
        .x_lin_flat       (x_lin_flat),
        .srdyo            (srdyo),
        .busy             (busy),
        .core_vld_o       (cif.core_vld_o),
        .core_rdy_i       (cif.core_rdy_i),
        .core_ch_o        (cif.core_ch_o),
        .core_x_adc_o     (cif.core_x_adc_o),
        .core_mode_o      (cif.core_mode_o),
        .core_vld_i       (cif.core_vld_i),
        .core_ch_i        (cif.core_ch_i),
        .core_x_lin_i     (cif.core_x_lin_i),
        .overrun_o        (overrun),
        .state_o          (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a frame with ch k sample = base+k; optionally push its expected results
    task automatic run_frame(input logic [XW-1:0] base, input logic [1:0] mode,
                             input int lat_exp, input bit expect_done, output int t0);
        logic [NUM_CH*XW-1:0] e;
        for (int k = 0; k < NUM_CH; k++) begin
            x_adc_flat[k*XW +: XW] = base + XW'(k);
            e[k*XW +: XW]          = base + XW'(k) + XW'(1);
        end
        op_mode = mode;
        srdyi   = 1'b1;
        t0      = cyc;
        if (expect_done) begin
            exp_q.push_back(e);
            exp_cyc_q.push_back(t0 + lat_exp);
        end
        @(posedge clk); #1;
        srdyi = 1'b0;
    endtask

    task automatic wait_frame(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout actual=no_srdyo expected=srdyo within %0d cycles", limit);
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    // Core model: latency LAT loopback returning x+1, or reversed batch return
    initial begin
        cif.core_vld_i   = 1'b0;
        cif.core_ch_i    = '0;
        cif.core_x_lin_i = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_ch.delete();
                pend_x.delete();
                pend_due.delete();
                rev_go = 1'b0;
            end else if (cif.core_vld_o && cif.core_rdy_i) begin
                pend_ch.push_back(cif.core_ch_o);
                pend_x.push_back(cif.core_x_adc_o + XW'(1));
                pend_due.push_back(cyc + LAT);
            end
            @(posedge clk); #1;
            cif.core_vld_i   = 1'b0;
            cif.core_ch_i    = '0;
            cif.core_x_lin_i = '0;
            if (inj_pend) begin
                cif.core_vld_i   = 1'b1;
                cif.core_ch_i    = inj_ch;
                cif.core_x_lin_i = inj_x;
                inj_pend         = 1'b0;
            end else if (rev_mode) begin
                if (pend_ch.size() == NUM_CH) rev_go = 1'b1;
                if (rev_go && pend_ch.size() > 0) begin
                    cif.core_vld_i   = 1'b1;
                    cif.core_ch_i    = pend_ch.pop_back();
                    cif.core_x_lin_i = pend_x.pop_back();
                    void'(pend_due.pop_back());
                    if (pend_ch.size() == 0) rev_go = 1'b0;
                end
            end else if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                cif.core_vld_i   = 1'b1;
                cif.core_ch_i    = pend_ch.pop_front();
                cif.core_x_lin_i = pend_x.pop_front();
                void'(pend_due.pop_front());
            end
        end
    end

    // Monitor: every srdyo pops one expected frame and checks timing and data
    initial begin
        logic [NUM_CH*XW-1:0] e;
        int                   ec;
        forever begin
            @(negedge clk);
            if (srdyo === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_srdyo actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("srdyo_cycle", cyc, ec);
                    for (int k = 0; k < NUM_CH; k++) begin
                        check($sformatf("xlin_ch%0d", k), x_lin_flat[k*XW +: XW], e[k*XW +: XW]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int t0;
        rst_n           = 1'b0;
        srdyi           = 1'b0;
        op_mode         = 2'b00;
        x_adc_flat      = '0;
        cif.core_rdy_i  = 1'b1;
        inj_ch          = '0;
        inj_x           = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_srdyo",   srdyo, 0);
        check("rst_busy",    busy, 0);
        check("rst_vld",     cif.core_vld_o, 0);
        check("rst_ch",      cif.core_ch_o, 0);
        check("rst_x",       cif.core_x_adc_o, 0);
        check("rst_mode",    cif.core_mode_o, 0);
        check("rst_overrun", overrun, 0);
        check("rst_xlin",    32'(x_lin_flat == '0), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame, mode 01
        run_frame(21'd0, 2'b01, 20, 1'b1, t0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("a_busy", busy, 1);
        check("a_vld",  cif.core_vld_o, 1);
        check("a_ch",   cif.core_ch_o, 2);
        check("a_x",    cif.core_x_adc_o, 2);
        check("a_mode", cif.core_mode_o, 1);
        wait_frame(60);
        repeat (3) @(posedge clk);
        #1;
        check("a_hold_ch7", x_lin_flat[7*XW +: XW], 8);
        check("a_idle_busy", busy, 0);
        inj_ch   = 4'd3;
        inj_x    = 21'h1abcd;
        inj_pend = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ignore_ch3", x_lin_flat[3*XW +: XW], 4);

        // Back-pressure: ready low for 4 cycles while ch5 is presented
        run_frame(21'h100, 2'b10, 24, 1'b1, t0);
        repeat (5) @(posedge clk);
        #1;
        cif.core_rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_vld", cif.core_vld_o, 1);
            check("bp_ch",  cif.core_ch_o, 5);
            check("bp_x",   cif.core_x_adc_o, 21'h105);
            @(posedge clk); #1;
        end
        cif.core_rdy_i = 1'b1;
        wait_frame(80);

        // Reversed result order
        rev_mode = 1'b1;
        run_frame(21'h1fff00, 2'b11, 33, 1'b1, t0);
        wait_frame(80);
        rev_mode = 1'b0;

        // Overrun: second srdyi at cycle 5 of the frame with different data
        run_frame(21'h040, 2'b00, 20, 1'b1, t0);
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < NUM_CH; k++) x_adc_flat[k*XW +: XW] = 21'h0aaaa;
        op_mode = 2'b10;
        srdyi   = 1'b1;
        @(posedge clk); #1;
        srdyi = 1'b0;
        check("ovr_busy", busy, 1);
        @(negedge clk);
        check("ovr_flag", overrun, OVR_EXP);
        check("ovr_mode", cif.core_mode_o, 0);
        wait_frame(60);
        repeat (2) @(posedge clk);
        #1;
        check("ovr_sticky", overrun, OVR_EXP);

        // Reset while ch8 is being issued; frame must be abandoned
        run_frame(21'h333, 2'b01, 20, 1'b0, t0);
        repeat (8) @(posedge clk);
        #1;
        check("pre_abort_ch", cif.core_ch_o, 8);
        rst_n = 1'b0;
        #1;
        check("abort_vld",     cif.core_vld_o, 0);
        check("abort_ch",      cif.core_ch_o, 0);
        check("abort_x",       cif.core_x_adc_o, 0);
        check("abort_mode",    cif.core_mode_o, 0);
        check("abort_busy",    busy, 0);
        check("abort_srdyo",   srdyo, 0);
        check("abort_overrun", overrun, 0);
        check("abort_state",   state_dbg, ST_IDLE);
        check("abort_xlin",    32'(x_lin_flat == '0), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;

        // Normal frame after the abort
        run_frame(21'h0777, 2'b10, 20, 1'b1, t0);
        wait_frame(60);

        repeat (5) @(posedge clk);
        #1;
        check("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
